// File: rtl/ucsbece154_mem_pkg.sv
// Shared types and constants for the SDRAM read-port arbiter.
package ucsbece154_mem_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } arbState_t;

  // Requester identifiers; also the bit positions in the pick request/grant vectors.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Default number of beats in one SDRAM burst.
  localparam int BLOCK_WORDS_DEFAULT = 4;

endpackage

// File: rtl/ucsbece154_mem_arbiter_if.sv
// Bundle of cache-miss, SDRAM read-port and beat-return signals around the arbiter.
// The master modport is the arbiter side; the slave modport is the caches plus SDRAM.
interface ucsbece154_mem_arbiter_if #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);

  // Requester side
  logic              IReq;
  logic [ADDR_W-1:0] IAddr;
  logic              DReq;
  logic [ADDR_W-1:0] DAddr;
  logic              IGrant;
  logic              DGrant;
  logic              IDataReady;
  logic              DDataReady;
  logic              IDone;
  logic              DDone;
  logic [IDX_W-1:0]  BeatIdx;
  logic [DATA_W-1:0] DataOut;

  // SDRAM side
  logic              MemReadRequest;
  logic [ADDR_W-1:0] MemReadAddress;
  logic [DATA_W-1:0] MemDataIn;
  logic              MemDataReady;

  // Status
  logic              ProtErr;

  modport master (
    input  IReq, IAddr, DReq, DAddr, MemDataIn, MemDataReady,
    output IGrant, DGrant, IDataReady, DDataReady, IDone, DDone,
           BeatIdx, DataOut, MemReadRequest, MemReadAddress, ProtErr
  );

  modport slave (
    output IReq, IAddr, DReq, DAddr, MemDataIn, MemDataReady,
    input  IGrant, DGrant, IDataReady, DDataReady, IDone, DDone,
           BeatIdx, DataOut, MemReadRequest, MemReadAddress, ProtErr
  );

endinterface

// File: rtl/ucsbece154_rr_pick2.sv
// Two-input round-robin picker: a lone request wins outright, a tie goes to
// whichever requester did not win last time. Output is one-hot (or zero).
module ucsbece154_rr_pick2
  import ucsbece154_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // Resolve ties against the previous winner; otherwise pass the request through.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last == REQ_I) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ucsbece154_mem_arbiter.sv
// Shares the single SDRAM read port between the I-cache and D-cache miss engines.
// One burst is in flight at a time; its beats are counted and routed to the
// granted cache. A requester that withdraws mid-burst has the rest of its burst
// drained without being forwarded.
module ucsbece154_mem_arbiter
  import ucsbece154_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  ucsbece154_mem_arbiter_if.master bus
);

  localparam int               IDX_W     = $clog2(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0] ONE_BEAT  = IDX_W'(1);

  arbState_t         state, stateNext;
  logic              grantI, grantINext;
  logic              grantD, grantDNext;
  logic              readReq, readReqNext;
  logic [ADDR_W-1:0] readAddr, readAddrNext;
  logic [IDX_W-1:0]  beatCnt, beatCntNext;
  logic              last, lastNext;
  logic              protErr, protErrNext;

  logic              beatFwd;
  logic              beatDone;
  logic              grantedReq;
  logic [1:0]        pickReq;
  logic [1:0]        pickGrant;
  logic [DATA_W-1:0] dataPass;

  assign pickReq    = {bus.DReq, bus.IReq};
  assign grantedReq = (grantI & bus.IReq) | (grantD & bus.DReq);

  ucsbece154_rr_pick2 picker (
    .req   (pickReq),
    .last  (last),
    .grant (pickGrant)
  );

  // State and all registered outputs; async active-low reset abandons any burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grantI   <= 1'b0;
      grantD   <= 1'b0;
      readReq  <= 1'b0;
      readAddr <= '0;
      beatCnt  <= '0;
      last     <= REQ_I;
      protErr  <= 1'b0;
    end else begin
      state    <= stateNext;
      grantI   <= grantINext;
      grantD   <= grantDNext;
      readReq  <= readReqNext;
      readAddr <= readAddrNext;
      beatCnt  <= beatCntNext;
      last     <= lastNext;
      protErr  <= protErrNext;
    end
  end

  // Next-state logic plus the combinational beat-forward and last-beat strobes.
  always_comb begin
    stateNext    = state;
    grantINext   = grantI;
    grantDNext   = grantD;
    readReqNext  = 1'b0;
    readAddrNext = readAddr;
    beatCntNext  = beatCnt;
    lastNext     = last;
    protErrNext  = protErr;
    beatFwd      = 1'b0;
    beatDone     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.MemDataReady) begin
          protErrNext = 1'b1;
        end
        if (pickGrant != 2'b00) begin
          stateNext    = ISSUE;
          grantINext   = pickGrant[REQ_I];
          grantDNext   = pickGrant[REQ_D];
          readAddrNext = pickGrant[REQ_D] ? bus.DAddr : bus.IAddr;
          lastNext     = pickGrant[REQ_D] ? REQ_D : REQ_I;
          readReqNext  = 1'b1;
          beatCntNext  = '0;
        end
      end

      ISSUE: begin
        // The read strobe goes out this cycle whatever happens, so a withdrawal
        // here still has a full burst coming back that must be drained.
        if (bus.MemDataReady) begin
          protErrNext = 1'b1;
        end
        beatCntNext = '0;
        stateNext   = grantedReq ? BURST : DRAIN;
      end

      BURST: begin
        if (bus.MemDataReady) begin
          beatFwd     = 1'b1;
          beatCntNext = beatCnt + ONE_BEAT;
          if (beatCnt == LAST_BEAT) begin
            beatDone   = 1'b1;
            grantINext = 1'b0;
            grantDNext = 1'b0;
            stateNext  = IDLE;
          end else if (!grantedReq) begin
            stateNext = DRAIN;
          end
        end else if (!grantedReq) begin
          stateNext = DRAIN;
        end
      end

      DRAIN: begin
        if (bus.MemDataReady) begin
          beatCntNext = beatCnt + ONE_BEAT;
          if (beatCnt == LAST_BEAT) begin
            grantINext = 1'b0;
            grantDNext = 1'b0;
            stateNext  = IDLE;
          end
        end
      end

      default: begin
        stateNext  = IDLE;
        grantINext = 1'b0;
        grantDNext = 1'b0;
      end
    endcase
  end

  assign dataPass = bus.MemDataIn;

  assign bus.IGrant         = grantI;
  assign bus.DGrant         = grantD;
  assign bus.IDataReady     = beatFwd & grantI;
  assign bus.DDataReady     = beatFwd & grantD;
  assign bus.IDone          = beatDone & grantI;
  assign bus.DDone          = beatDone & grantD;
  assign bus.BeatIdx        = beatCnt;
  assign bus.DataOut        = dataPass;
  assign bus.MemReadRequest = readReq;
  assign bus.MemReadAddress = readAddr;
  assign bus.ProtErr        = protErr;

endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// Scoreboard bench for the SDRAM read-port arbiter: expected read strobes and
// forwarded beats are queued as stimulus is driven and popped by a monitor.
module tb_ucsbece154_mem_arbiter;

  logic clk;
  logic reset;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic        who;
    logic [1:0]  idx;
    logic [31:0] data;
    logic        done;
  } beat_t;

  typedef struct {
    logic        who;
    logic [31:0] addr;
  } strobe_t;

  beat_t   beatQ[$];
  strobe_t strobeQ[$];
  beat_t   expBeat;
  strobe_t expStrobe;
  int      cycles;

  ucsbece154_mem_arbiter_if bus ();

  ucsbece154_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic [31:0] dAddr);
    step();
    bus.IReq  = iReq;
    bus.IAddr = iAddr;
    bus.DReq  = dReq;
    bus.DAddr = dAddr;
  endtask

  task automatic waitStrobe(output int n);
    bit found;
    found = 0;
    n = 0;
    while (!found && n < 20) begin
      step();
      n++;
      if (bus.MemReadRequest) found = 1;
    end
    if (!found) checkOutput("strobeTimeout", 64'd0, 64'd1);
  endtask

  task automatic dropReq(input logic who);
    if (who) bus.DReq = 1'b0;
    else     bus.IReq = 1'b0;
  endtask

  // Four beats with a bubble before beat 2; optional withdrawal after a beat.
  task automatic driveBeats(input logic who, input int withdrawAfter,
                            input bit dropAtEnd, input logic [31:0] base);
    bit    fwd;
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      if (withdrawAfter >= 0 && i == withdrawAfter + 1) begin
        step();
        bus.MemDataReady = 1'b0;
        dropReq(who);
      end else if (i == 2) begin
        step();
        bus.MemDataReady = 1'b0;
      end
      fwd = (withdrawAfter < 0) || (i <= withdrawAfter);
      step();
      bus.MemDataReady = 1'b1;
      bus.MemDataIn    = base + 32'(i);
      if (fwd) begin
        b.who  = who;
        b.idx  = 2'(i);
        b.data = base + 32'(i);
        b.done = (i == 3);
        beatQ.push_back(b);
      end
    end
    step();
    bus.MemDataReady = 1'b0;
    if (dropAtEnd) dropReq(who);
    checkOutput("grantClr", {62'd0, bus.DGrant, bus.IGrant}, 64'd0);
  endtask

  // Monitor: compare every read strobe and every forwarded beat against the queues.
  always @(negedge clk) begin
    if (bus.MemReadRequest) begin
      if (strobeQ.size() == 0) begin
        checkOutput("unexpStrobe", 64'd1, 64'd0);
      end else begin
        expStrobe = strobeQ.pop_front();
        checkOutput("strobeAddr", {32'd0, bus.MemReadAddress}, {32'd0, expStrobe.addr});
        checkOutput("strobeGrant", {62'd0, bus.DGrant, bus.IGrant},
                    expStrobe.who ? 64'd2 : 64'd1);
      end
    end
    if (bus.IDataReady || bus.DDataReady) begin
      if (beatQ.size() == 0) begin
        checkOutput("unexpBeat", {62'd0, bus.DDataReady, bus.IDataReady}, 64'd0);
      end else begin
        expBeat = beatQ.pop_front();
        checkOutput("beatReady", {62'd0, bus.DDataReady, bus.IDataReady},
                    expBeat.who ? 64'd2 : 64'd1);
        checkOutput("beatIdx", {62'd0, bus.BeatIdx}, {62'd0, expBeat.idx});
        checkOutput("beatData", {32'd0, bus.DataOut}, {32'd0, expBeat.data});
        checkOutput("beatDone", {62'd0, bus.DDone, bus.IDone},
                    expBeat.done ? (expBeat.who ? 64'd2 : 64'd1) : 64'd0);
      end
    end else if (bus.IDone || bus.DDone) begin
      checkOutput("strayDone", {62'd0, bus.DDone, bus.IDone}, 64'd0);
    end
    if (bus.IGrant && bus.DGrant) begin
      checkOutput("grantExcl", 64'd3, 64'd0);
    end
  end

  // Test sequence.
  initial begin
    logic who;
    bus.IReq         = 1'b0;
    bus.IAddr        = '0;
    bus.DReq         = 1'b0;
    bus.DAddr        = '0;
    bus.MemDataIn    = '0;
    bus.MemDataReady = 1'b0;
    reset            = 1'b0;
    repeat (3) step();
    checkOutput("rstGrant", {62'd0, bus.DGrant, bus.IGrant}, 64'd0);
    checkOutput("rstStrobe", {63'd0, bus.MemReadRequest}, 64'd0);
    checkOutput("rstAddr", {32'd0, bus.MemReadAddress}, 64'd0);
    checkOutput("rstProt", {63'd0, bus.ProtErr}, 64'd0);
    reset = 1'b1;

    $display("[TB] tie after reset: D first, then I");
    strobeQ.push_back('{who: 1'b1, addr: 32'h200});
    strobeQ.push_back('{who: 1'b0, addr: 32'h300});
    applyStimulus(1'b1, 32'h300, 1'b1, 32'h200);
    waitStrobe(cycles);
    checkOutput("issueLatency", 64'(cycles), 64'd1);
    driveBeats(1'b1, -1, 1'b1, 32'h20);
    waitStrobe(cycles);
    checkOutput("iAfterD", 64'(cycles), 64'd1);
    driveBeats(1'b0, -1, 1'b1, 32'h30);

    $display("[TB] I-only miss at 0x100");
    strobeQ.push_back('{who: 1'b0, addr: 32'h100});
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0);
    waitStrobe(cycles);
    checkOutput("iLatency", 64'(cycles), 64'd1);
    driveBeats(1'b0, -1, 1'b1, 32'hA);

    $display("[TB] continuous contention");
    for (int k = 0; k < 4; k++) begin
      strobeQ.push_back('{who: (k % 2 == 0), addr: (k % 2 == 0) ? 32'h880 : 32'h440});
    end
    applyStimulus(1'b1, 32'h440, 1'b1, 32'h880);
    for (int k = 0; k < 4; k++) begin
      who = (k % 2 == 0);
      waitStrobe(cycles);
      checkOutput("altLatency", 64'(cycles), 64'd1);
      driveBeats(who, -1, 1'b0, 32'h1000 * (k + 1));
    end
    bus.IReq = 1'b0;
    bus.DReq = 1'b0;

    $display("[TB] I withdraws after beat 1 with D pending");
    strobeQ.push_back('{who: 1'b0, addr: 32'h400});
    applyStimulus(1'b1, 32'h400, 1'b0, 32'h0);
    waitStrobe(cycles);
    bus.DReq  = 1'b1;
    bus.DAddr = 32'h500;
    driveBeats(1'b0, 1, 1'b0, 32'h40);
    strobeQ.push_back('{who: 1'b1, addr: 32'h500});
    waitStrobe(cycles);
    checkOutput("dAfterDrain", 64'(cycles), 64'd1);
    driveBeats(1'b1, -1, 1'b1, 32'h50);

    $display("[TB] stray MemDataReady in IDLE");
    step();
    checkOutput("protBefore", {63'd0, bus.ProtErr}, 64'd0);
    bus.MemDataReady = 1'b1;
    bus.MemDataIn    = 32'hDEAD;
    #1;
    checkOutput("protFwd", {62'd0, bus.DDataReady, bus.IDataReady}, 64'd0);
    step();
    bus.MemDataReady = 1'b0;
    checkOutput("protSet", {63'd0, bus.ProtErr}, 64'd1);
    repeat (3) step();
    checkOutput("protSticky", {63'd0, bus.ProtErr}, 64'd1);

    $display("[TB] reset mid-burst");
    strobeQ.push_back('{who: 1'b0, addr: 32'h600});
    applyStimulus(1'b1, 32'h600, 1'b0, 32'h0);
    waitStrobe(cycles);
    for (int i = 0; i < 2; i++) begin
      step();
      bus.MemDataReady = 1'b1;
      bus.MemDataIn    = 32'h60 + 32'(i);
      beatQ.push_back('{who: 1'b0, idx: 2'(i), data: 32'h60 + 32'(i), done: 1'b0});
    end
    step();
    bus.MemDataReady = 1'b0;
    bus.IReq         = 1'b0;
    reset            = 1'b0;
    #1;
    checkOutput("midRstGrant", {62'd0, bus.DGrant, bus.IGrant}, 64'd0);
    checkOutput("midRstStrobe", {63'd0, bus.MemReadRequest}, 64'd0);
    checkOutput("midRstAddr", {32'd0, bus.MemReadAddress}, 64'd0);
    checkOutput("midRstIdx", {62'd0, bus.BeatIdx}, 64'd0);
    checkOutput("midRstProt", {63'd0, bus.ProtErr}, 64'd0);
    step();
    step();
    reset = 1'b1;
    strobeQ.push_back('{who: 1'b1, addr: 32'h700});
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h700);
    waitStrobe(cycles);
    checkOutput("postRstLatency", 64'(cycles), 64'd1);
    driveBeats(1'b1, -1, 1'b1, 32'h70);

    repeat (3) step();
    checkOutput("queuesEmpty", 64'(beatQ.size() + strobeQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ucsbece154_mem_arbiter.md
# ucsbece154_mem_arbiter

Read-port arbiter and burst sequencer that shares the single SDRAM instruction/data backing-store read port between the instruction cache (requester I) and the data cache (requester D). Sits between both cache miss engines and `ucsbece154_imem`: grants one requester at a time, issues the SDRAM read, counts the returning burst beats and routes them back. Handles a requester withdrawing mid-burst (e.g. fetch flush) by draining the burst silently.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data word width.
- `BLOCK_WORDS`, 4, beats per SDRAM burst; power of two, ≥2.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `IReq`  in  1  I-cache miss request; held until `IDone` or withdrawn.
- `IAddr`  in  ADDR_W  I-cache block address; stable while `IReq`.
- `DReq`  in  1  D-cache miss request; same rules.
- `DAddr`  in  ADDR_W  D-cache block address.
- `IGrant`  out  1  registered; burst in flight belongs to I.
- `DGrant`  out  1  registered; burst belongs to D.
- `IDataReady`  out  1  beat valid for I.
- `DDataReady`  out  1  beat valid for D.
- `IDone`, `DDone`  out  1  final beat of that requester's burst.
- `BeatIdx`  out  clog2(BLOCK_WORDS)  index of current beat.
- `DataOut`  out  DATA_W  `MemDataIn` broadcast to both caches.
- `MemReadRequest`  out  1  registered one-cycle SDRAM read strobe.
- `MemReadAddress`  out  ADDR_W  registered, held for whole burst.
- `MemDataIn`  in  DATA_W  SDRAM beat data.
- `MemDataReady`  in  1  SDRAM beat valid.
- `ProtErr`  out  1  sticky; `MemDataReady` seen outside BURST/DRAIN.

## Operation
- States: IDLE, ISSUE, BURST, DRAIN.
- IDLE: if any request, pick winner, capture its address into `MemReadAddress`, set its grant, go ISSUE. Else stay.
- Arbitration: round-robin. A `last` bit records the previous winner; on simultaneous `IReq`/`DReq` the other requester wins. `last` resets to I, so D wins the first tie.
- ISSUE: `MemReadRequest`=1 for exactly this cycle; beat counter cleared; go BURST.
- BURST: each `MemDataReady` increments counter and asserts granted `xDataReady`. Beats need not be consecutive. On beat `BLOCK_WORDS-1` assert granted `xDone`, clear grants, go IDLE.
- Withdrawal: if the granted `xReq` is low in ISSUE or BURST, go DRAIN (from ISSUE only after the strobe is sent). DRAIN counts remaining beats with no `xDataReady`/`xDone`, then clears grants and goes IDLE. A re-raised request during DRAIN waits for IDLE.
- `xDataReady`, `xDone` are combinational from `MemDataReady`, state, grant and counter. All other outputs are registered.
- Counter width is clog2(BLOCK_WORDS); it wraps naturally at the last beat.
- `MemDataReady` in IDLE/ISSUE is not forwarded and sets `ProtErr`. `ProtErr` clears only on reset.

## Timing
- Reset (async, `reset`=0): state IDLE, grants 0, `MemReadRequest` 0, `MemReadAddress` 0, counter 0, `last`=I, `ProtErr` 0. Reset mid-burst abandons the burst; the SDRAM model is reset by the same signal.
- Request sampled in IDLE at edge N → grant and `MemReadRequest` high in cycle N+1 → BURST from N+2.
- Final beat in cycle M → IDLE in M+1 → next `MemReadRequest` no earlier than M+2. The minimum gap is one idle cycle.
- `IDone` same cycle as last `IDataReady`. The requester must drop `IReq` by the next edge or it is re-arbitrated as a new miss.

## Structure
- Package `ucsbece154_mem_pkg`: state enum (IDLE/ISSUE/BURST/DRAIN), requester ID constants (REQ_I=0, REQ_D=1), `BLOCK_WORDS` default.
- One sub-module: `ucsbece154_rr_pick2`, a two-input round-robin picker taking `req[1:0]` and `last` and returning a one-hot grant. Everything else stays in the arbiter.

## Test plan
- I-only miss at 0x100, SDRAM returns 4 beats A,B,C,D with one bubble → `MemReadRequest` one cycle with addr 0x100; `IDataReady` ×4 with `BeatIdx` 0..3; `IDone` on D; `DDataReady` never.
- `IReq`/`DReq` raised same cycle after reset → D served first; I is granted two cycles after D's last beat.
- Continuous contention for 4 bursts → strict alternation D,I,D,I.
- I withdraws after beat 1 → remaining 2 beats produce no `IDataReady`/`IDone`; `DReq` pending meanwhile is issued only after beat 3.
- `MemDataReady` pulsed in IDLE → nothing forwarded; `ProtErr`=1 and stays 1.
- `reset` asserted mid-BURST → all outputs return to reset values asynchronously; a new miss after release proceeds normally with `BeatIdx` starting at 0.
